mem_arbiter: RTL and testbench

Shares a single external memory port between the core's instruction-fetch side and its load/store side. It sits between the rv32im core's I-cache/D-cache request interfaces and one unified memory, such as on-chip SRAM or a bus bridge. It registers each granted request, holds the memory port stable until the memory accepts and completes the access, and returns read data with a one-cycle ready pulse to the winning requester.

---
 rtl/rv32_mem_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types for the memory arbiter: controller state and grant side encoding.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_side_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the fetch/load-store memory arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects alternating grants on
// conflict; without it the data side always wins a conflict.
module mem_arb_pick
    import rv32_mem_pkg::*;
(
    input  logic        i_pend_i,
    input  logic        i_pend_d,
    input  grant_side_t i_last_grant,
    output logic        o_grant_valid,
    output grant_side_t o_grant_side
);

    grant_side_t w_conflict_side;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On conflict, serve whichever side did not win the previous grant.
    always_comb w_conflict_side = (i_last_grant == GNT_I) ? GNT_D : GNT_I;
`else
    logic w_unused_last;
    assign w_unused_last = i_last_grant;

    // On conflict the load/store side always wins.
    always_comb w_conflict_side = GNT_D;
`endif

    // Pick a side: the single requester, or the conflict winner when both ask.
    always_comb begin
        o_grant_valid = i_pend_i | i_pend_d;
        o_grant_side  = GNT_I;
        if (i_pend_i && i_pend_d) begin
            o_grant_side = w_conflict_side;
        end else if (i_pend_d) begin
            o_grant_side = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Each grant is registered, held on the memory port until mem_ready,
// and answered with a one-cycle ready pulse to the winning side.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin conflict resolution,
// handled inside mem_arb_pick); default build is fixed data-side priority.
module mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [31:0]           i_rdata,
    output logic                  i_ready,
    input  logic                  d_ren,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wmask,
    output logic [31:0]           d_rdata,
    output logic                  d_ready,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    grant_side_t           r_winner;
    grant_side_t           r_last_grant;
    grant_side_t           w_grant_side;
    logic                  w_grant_valid;
    logic                  w_pend_i;
    logic                  w_pend_d;
    logic                  w_busy;
    logic                  w_take_grant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wmask;
    logic [31:0]           r_resp;

    assign w_pend_i     = i_req;
    assign w_pend_d     = d_ren | d_wen;
    assign w_busy       = (r_state == ARB_BUSY_I) || (r_state == ARB_BUSY_D);
    assign w_take_grant = (r_state == ARB_IDLE) && w_grant_valid;

    // Last-grant is only consulted by the picker in round-robin builds.
    mem_arb_pick u_pick (
        .i_pend_i      (w_pend_i),
        .i_pend_d      (w_pend_d),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_side  (w_grant_side)
    );

    // State register; reset abandons any in-flight access immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: requests are only looked at in IDLE; BUSY waits for memory.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = (w_grant_side == GNT_D) ? ARB_BUSY_D : ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ready) begin
                    w_next_state = ARB_RESP;
                end
            end
            ARB_RESP: w_next_state = ARB_IDLE;
            default:  w_next_state = ARB_IDLE;
        endcase
    end

    // Capture the granted access and, later, the memory's read response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_winner     <= GNT_I;
            r_last_grant <= GNT_I;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_resp       <= '0;
        end else begin
            if (w_take_grant) begin
                r_winner     <= w_grant_side;
                r_last_grant <= w_grant_side;
                if (w_grant_side == GNT_D) begin
                    r_we    <= d_wen;
                    r_addr  <= d_addr;
                    r_wdata <= d_wen ? d_wdata : 32'd0;
                    r_wmask <= d_wen ? d_wmask : 4'b0000;
                end else begin
                    r_we    <= 1'b0;
                    r_addr  <= i_addr;
                    r_wdata <= 32'd0;
                    r_wmask <= 4'b0000;
                end
            end
            if (w_busy && mem_ready) begin
                r_resp <= r_we ? 32'd0 : mem_rdata;
            end
        end
    end

    assign mem_valid = w_busy;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;

    assign i_ready = (r_state == ARB_RESP) && (r_winner == GNT_I);
    assign d_ready = (r_state == ARB_RESP) && (r_winner == GNT_D);
    assign i_rdata = i_ready ? r_resp : 32'd0;
    assign d_rdata = d_ready ? r_resp : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// traffic, compared against a request-level model of the arbitration rules.
// Build option: MEM_ARB_ROUND_ROBIN_EN changes the expected conflict winner.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_ren = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Request-level model: what each side is asking for, and who won last.
    bit          pendI = 0;
    bit          pendD = 0;
    bit          lastWasD = 0;
    logic [31:0] mIAddr;
    logic [31:0] mDAddr;
    logic [31:0] mDWdata;
    logic [3:0]  mDMask;
    bit          mDWe;

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_ren     (d_ren),
        .d_wen     (d_wen),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Conflict winner rule: alternate in round-robin builds, else data side.
    function automatic bit predictWinnerIsD();
        if (pendI && pendD) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !lastWasD;
`else
            return 1'b1;
`endif
        end
        return pendD;
    endfunction

    task automatic raiseI(input logic [31:0] addr);
        i_req  = 1'b1;
        i_addr = addr;
        pendI  = 1;
        mIAddr = addr;
    endtask

    task automatic raiseD(input bit ren, input bit wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        d_ren   = ren;
        d_wen   = wen;
        d_addr  = addr;
        d_wdata = wdata;
        d_wmask = mask;
        pendD   = 1;
        mDAddr  = addr;
        mDWdata = wdata;
        mDMask  = mask;
        mDWe    = wen;
    endtask

    task automatic raiseDRandom();
        int t;
        t = $urandom_range(1, 3);
        raiseD(t[0], t[1], $urandom, $urandom, 4'($urandom));
    endtask

    task automatic checkFields(input bit winD, input string tag);
        if (winD) begin
            checkOutput({tag, "_addr"}, mem_addr, mDAddr);
            checkOutput({tag, "_we"}, mem_we, mDWe);
            checkOutput({tag, "_wmask"}, mem_wmask, mDWe ? mDMask : 4'b0000);
            if (mDWe) checkOutput({tag, "_wdata"}, mem_wdata, mDWdata);
        end else begin
            checkOutput({tag, "_addr"}, mem_addr, mIAddr);
            checkOutput({tag, "_we"}, mem_we, 1'b0);
            checkOutput({tag, "_wmask"}, mem_wmask, 4'b0000);
        end
    endtask

    // Serve the next access as the memory: expect mem_valid one cycle after
    // the arbiter idles with requests pending, stall 'waits' cycles, respond,
    // then check the ready pulse. reraise: 0 none, 1 random new request on
    // the winner side, 2 new plain load on the data side.
    task automatic applyStimulus(input int waits, input bit fixData, input logic [31:0] fixRdata,
                                 input int reraise);
        bit          winD;
        logic [31:0] rd;
        logic [31:0] expData;
        winD = predictWinnerIsD();
        rd   = fixData ? fixRdata : $urandom;
        step();
        checkOutput("mem_valid_rise", mem_valid, 1'b1);
        checkOutput("busy_no_ready", {i_ready, d_ready}, 2'b00);
        checkFields(winD, "grant");
        for (int j = 0; j <= waits; j++) begin
            mem_ready = (j == waits);
            mem_rdata = (j == waits) ? rd : $urandom;
            step();
            if (j < waits) begin
                checkOutput("stall_valid", mem_valid, 1'b1);
                checkOutput("stall_no_ready", {i_ready, d_ready}, 2'b00);
                checkFields(winD, "stall");
            end
        end
        mem_ready = 1'b0;
        expData = (winD && mDWe) ? 32'd0 : rd;
        checkOutput("resp_valid_low", mem_valid, 1'b0);
        if (winD) begin
            checkOutput("resp_d_ready", d_ready, 1'b1);
            checkOutput("resp_d_rdata", d_rdata, expData);
            checkOutput("resp_i_quiet", {i_ready, i_rdata}, 33'd0);
            d_ren = 1'b0;
            d_wen = 1'b0;
            pendD = 0;
        end else begin
            checkOutput("resp_i_ready", i_ready, 1'b1);
            checkOutput("resp_i_rdata", i_rdata, expData);
            checkOutput("resp_d_quiet", {d_ready, d_rdata}, 33'd0);
            i_req = 1'b0;
            pendI = 0;
        end
        lastWasD = winD;
        if (reraise == 2) begin
            raiseD(1'b1, 1'b0, $urandom, 32'd0, 4'b0000);
        end else if (reraise == 1) begin
            if (winD) raiseDRandom();
            else raiseI($urandom);
        end
        step();
        checkOutput("idle_no_ready", {i_ready, d_ready, mem_valid}, 3'b000);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, mem_valid, 1'b0);
        checkOutput({tag, "_we"}, mem_we, 1'b0);
        checkOutput({tag, "_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_wmask"}, mem_wmask, 4'b0000);
        checkOutput({tag, "_ready"}, {i_ready, d_ready}, 2'b00);
        checkOutput({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    endtask

    initial begin
        // Power-up reset.
        step();
        step();
        checkAllZero("reset");
        reset = 1'b1;
        step();
        checkAllZero("post_reset_idle");

        // Single store.
        $display("[TB] single store");
        raiseD(1'b0, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b1100);
        applyStimulus(3, 1'b0, 32'd0, 0);

        // Single fetch with two memory wait cycles.
        $display("[TB] single fetch");
        raiseI(32'h100);
        applyStimulus(2, 1'b1, 32'h00500093, 0);

        // Conflict in the same cycle, then held fetch versus a new load.
        $display("[TB] conflict");
        raiseI(32'h300);
        raiseD(1'b1, 1'b0, 32'h400, 32'd0, 4'b0000);
        checkOutput("conflict_first_is_d", predictWinnerIsD(), 1'b1);
        applyStimulus(1, 1'b0, 32'd0, 2);
        applyStimulus(0, 1'b0, 32'd0, 0);
        applyStimulus(1, 1'b0, 32'd0, 0);

        // Long stall on a store.
        $display("[TB] stall hold");
        raiseD(1'b0, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
        applyStimulus(10, 1'b0, 32'd0, 0);

        // Load and store requested together behave as a store.
        $display("[TB] ren and wen together");
        raiseD(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 4'b1111);
        applyStimulus(0, 1'b0, 32'd0, 0);

        // Random traffic.
        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            if (!pendI && !pendD) begin
                int r;
                r = $urandom_range(1, 3);
                if (r[0]) raiseI($urandom);
                if (r[1]) raiseDRandom();
            end
            applyStimulus($urandom_range(0, 3), 1'b0, 32'd0, ($urandom_range(0, 2) == 0) ? 1 : 0);
        end
        while (pendI || pendD) begin
            applyStimulus(0, 1'b0, 32'd0, 0);
        end

        // Reset in the middle of a store.
        $display("[TB] reset mid-access");
        raiseD(1'b0, 1'b1, 32'h5000, 32'hA5A5_A5A5, 4'b1010);
        step();
        checkOutput("pre_reset_busy", mem_valid, 1'b1);
        #2 reset = 1'b0;
        #1 checkAllZero("async_reset");
        d_wen = 1'b0;
        pendD = 0;
        lastWasD = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("reset_no_ready", {i_ready, d_ready}, 2'b00);
        end
        reset = 1'b1;
        step();
        checkOutput("after_reset_no_ready", {i_ready, d_ready, mem_valid}, 3'b000);
        raiseI(32'h200);
        applyStimulus(1, 1'b1, 32'h0000_0013, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
